// File: rtl/apb_led_pwm_pkg.sv
// apb_led_pwm_pkg: register indices and CTRL bit positions shared by the LED PWM peripheral.
package apb_led_pwm_pkg;
   localparam int REG_CTRL     = 0;
   localparam int REG_PRESCALE = 1;
   localparam int REG_BLINK    = 2;
   localparam int REG_MASK     = 3;
   localparam int REG_DUTY0    = 4;
   localparam int CTRL_EN      = 0;
endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED with its shadow duty, PWM compare and registered output.
module led_pwm_channel #(
   parameter int PWM_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [PWM_WIDTH-1:0] duty_i,
   input  logic                 load_i,
   input  logic [PWM_WIDTH-1:0] pwm_cnt_i,
   input  logic                 gate_i,
   output logic                 led_o
);
   logic [PWM_WIDTH-1:0] shadow_q, shadow_d;
   logic                 led_q, led_d;

   // All-ones duty is treated as fully on, since the compare alone would drop one count.
   always_comb begin
      shadow_d = load_i ? duty_i : shadow_q;
      led_d    = gate_i & ((&shadow_q) | (pwm_cnt_i < shadow_q));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q <= '0;
         led_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         led_q    <= led_d;
      end
   end

   assign led_o = led_q;
endmodule

// File: rtl/apb_led_pwm.sv
// apb_led_pwm: APB slave with register file, prescaled PWM timebase and blink generator
// driving NUM_LEDS PWM channels.
module apb_led_pwm
   import apb_led_pwm_pkg::*;
#(
   parameter int NUM_LEDS       = 16,
   parameter int PWM_WIDTH      = 8,
   parameter int APB_ADDR_WIDTH = 16,
   parameter int APB_DATA_WIDTH = 16
) (
   input  logic                      pclk,
   input  logic                      preset,
   input  logic                      i_psel,
   input  logic                      i_penable,
   input  logic                      i_pwrite,
   input  logic [APB_ADDR_WIDTH-1:0] i_paddr,
   input  logic [APB_DATA_WIDTH-1:0] i_pwdata,
   output logic                      o_pready,
   output logic [APB_DATA_WIDTH-1:0] o_prdata,
   output logic [NUM_LEDS-1:0]       o_leds
);
   localparam int AW = APB_ADDR_WIDTH;
   localparam int DW = APB_DATA_WIDTH;
   localparam int IW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;

   logic                 en_q;
   logic [DW-1:0]        prescale_q, blink_q;
   logic [NUM_LEDS-1:0]  mask_q;
   logic [PWM_WIDTH-1:0] duty_q [NUM_LEDS];
   logic                 pready_q, pready_d;
   logic [DW-1:0]        prdata_q, prdata_d, rd_val;
   logic [DW-1:0]        presc_q, presc_d, bcnt_q, bcnt_d;
   logic [PWM_WIDTH-1:0] pwm_q, pwm_d;
   logic                 phase_q, phase_d;
   logic                 tick, wrap, wr_en, is_duty;
   logic [IW-1:0]        duty_idx;

   always_comb begin
      is_duty  = (i_paddr >= AW'(REG_DUTY0)) && (i_paddr < AW'(REG_DUTY0 + NUM_LEDS));
      duty_idx = IW'(i_paddr - AW'(REG_DUTY0));
      rd_val   = '0;
      if (i_paddr == AW'(REG_CTRL)) rd_val[CTRL_EN] = en_q;
      else if (i_paddr == AW'(REG_PRESCALE)) rd_val = prescale_q;
      else if (i_paddr == AW'(REG_BLINK)) rd_val = blink_q;
      else if (i_paddr == AW'(REG_MASK)) rd_val[NUM_LEDS-1:0] = mask_q;
      else if (is_duty) rd_val[PWM_WIDTH-1:0] = duty_q[duty_idx];
      pready_d = i_psel & i_penable & ~pready_q;
      prdata_d = pready_d ? rd_val : '0;
      wr_en    = i_psel & i_penable & pready_q & i_pwrite;
      tick     = en_q & (presc_q == prescale_q);
      wrap     = tick & (&pwm_q);
      presc_d  = (!en_q || tick) ? '0 : presc_q + 1'b1;
      pwm_d    = !en_q ? '0 : pwm_q + PWM_WIDTH'(tick);
      bcnt_d   = !en_q ? '0 : !wrap ? bcnt_q : (bcnt_q == blink_q) ? '0 : bcnt_q + 1'b1;
      phase_d  = !en_q | (phase_q ^ (wrap & (bcnt_q == blink_q)));
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         en_q       <= 1'b0;
         prescale_q <= '0;
         blink_q    <= '0;
         mask_q     <= '0;
         for (int i = 0; i < NUM_LEDS; i++) duty_q[i] <= '0;
      end else if (wr_en) begin
         if (i_paddr == AW'(REG_CTRL)) en_q <= i_pwdata[CTRL_EN];
         if (i_paddr == AW'(REG_PRESCALE)) prescale_q <= i_pwdata;
         if (i_paddr == AW'(REG_BLINK)) blink_q <= i_pwdata;
         if (i_paddr == AW'(REG_MASK)) mask_q <= i_pwdata[NUM_LEDS-1:0];
         if (is_duty) duty_q[duty_idx] <= i_pwdata[PWM_WIDTH-1:0];
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         pready_q <= 1'b0;
         prdata_q <= '0;
         presc_q  <= '0;
         pwm_q    <= '0;
         bcnt_q   <= '0;
         phase_q  <= 1'b1;
      end else begin
         pready_q <= pready_d;
         prdata_q <= prdata_d;
         presc_q  <= presc_d;
         pwm_q    <= pwm_d;
         bcnt_q   <= bcnt_d;
         phase_q  <= phase_d;
      end
   end

   // Shadows follow DUTY continuously while disabled so enabling starts with fresh duties.
   for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
      led_pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_ch (
         .clk_i    (pclk),
         .rst_i    (preset),
         .duty_i   (duty_q[g]),
         .load_i   (wrap | ~en_q),
         .pwm_cnt_i(pwm_q),
         .gate_i   (en_q & (~mask_q[g] | phase_q)),
         .led_o    (o_leds[g])
      );
   end

   assign o_pready = pready_q;
   assign o_prdata = prdata_q;
endmodule

// File: tb/tb_apb_led_pwm.sv
// tb_apb_led_pwm: directed APB/LED bench; read data is checked by a scoreboard monitor
// on o_pready, LED waveforms by counting on-cycles over known windows.
module tb_apb_led_pwm;
   typedef struct {
      int          addr;
      logic [15:0] data;
   } rd_t;

   logic        clk = 1'b0;
   logic        preset = 1'b1;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [15:0] paddr = '0, pwdata = '0;
   logic        o_pready;
   logic [15:0] o_prdata;
   logic [15:0] o_leds;
   rd_t         sb[$];
   int          passed = 0, total = 0;

   apb_led_pwm dut (
      .pclk     (clk),
      .preset   (preset),
      .i_psel   (psel),
      .i_penable(penable),
      .i_pwrite (pwrite),
      .i_paddr  (paddr),
      .i_pwdata (pwdata),
      .o_pready (o_pready),
      .o_prdata (o_prdata),
      .o_leds   (o_leds)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   always @(negedge clk) begin
      rd_t e;
      if (o_pready && psel && penable && !pwrite) begin
         if (sb.size() == 0) check("rd_unexpected", 1, 0);
         else begin
            e = sb.pop_front();
            check($sformatf("rdata[0x%0h]", e.addr), int'(o_prdata), int'(e.data));
         end
      end
   end

   task automatic apb(input bit wr, input int addr, input logic [15:0] d, input logic [15:0] exp);
      int n;
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = 16'(addr); pwdata = d;
      @(negedge clk);
      penable = 1'b1;
      if (!wr) sb.push_back('{addr, exp});
      n = 0;
      @(negedge clk);
      while (!o_pready && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("pready_latency", n, 0);
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      check("pready_one_cycle", int'(o_pready), 0);
   endtask

   task automatic wr(input int addr, input logic [15:0] d);
      apb(1'b1, addr, d, 16'h0);
   endtask

   task automatic rd(input int addr, input logic [15:0] exp);
      apb(1'b0, addr, 16'h0, exp);
   endtask

   task automatic count_led(input int b, input int n, output int c);
      c = 0;
      repeat (n) begin
         @(negedge clk);
         c += int'(o_leds[b]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1, others, n;
      repeat (3) @(negedge clk);
      check("rst_pready", int'(o_pready), 0);
      check("rst_prdata", int'(o_prdata), 0);
      check("rst_leds", int'(o_leds), 0);
      preset = 1'b0;
      for (int a = 0; a <= 20; a++) rd(a, 16'h0);
      // 25% duty, tick every cycle; upper write bits are discarded
      wr(4, 16'hAB40);
      wr(1, 16'h0);
      wr(0, 16'h0003);
      rd(4, 16'h0040);
      rd(0, 16'h0001);
      repeat (300) @(negedge clk);
      c0 = 0; others = 0;
      repeat (256) begin
         @(negedge clk);
         c0 += int'(o_leds[0]);
         if (o_leds[15:1] != 0) others++;
      end
      check("duty40_on_cycles", c0, 64);
      check("other_leds_off", others, 0);
      wr(4, 16'h00FF);
      repeat (520) @(negedge clk);
      count_led(0, 256, c0);
      check("dutyFF_on_cycles", c0, 256);
      // duty 1 makes LED0 pulse right after each wrap, marking the wrap edge
      wr(4, 16'h0001);
      repeat (600) @(negedge clk);
      n = 0;
      while (o_leds[0] && n < 600) begin @(negedge clk); n++; end
      while (!o_leds[0] && n < 600) begin @(negedge clk); n++; end
      check("wrap_marker_found", int'(n < 600), 1);
      repeat (251) @(negedge clk);
      wr(7, 16'h0080);
      count_led(3, 256, c0);
      check("duty3_old_period", c0, 0);
      count_led(3, 256, c0);
      check("duty3_new_period", c0, 128);
      // blink: period 1024 cycles, phase toggles every 2 periods
      wr(0, 16'h0);
      wr(1, 16'h3);
      wr(2, 16'h1);
      wr(3, 16'h1);
      wr(4, 16'h00FF);
      wr(5, 16'h00FF);
      wr(0, 16'h1);
      c0 = 0; c1 = 0;
      repeat (2048) begin @(negedge clk); c0 += int'(o_leds[0]); c1 += int'(o_leds[1]); end
      check("blink_led0_on_phase", c0, 2048);
      count_led(0, 2048, c0);
      check("blink_led0_off_phase", c0, 0);
      check("blink_led1_steady", c1, 2048);
      wr(0, 16'h0);
      check("disable_led1_still_on", int'(o_leds[1]), 1);
      @(negedge clk);
      check("disable_leds_off", int'(o_leds), 0);
      repeat (37) @(negedge clk);
      wr(0, 16'h1);
      count_led(0, 2048, c0);
      check("reenable_led0_on_phase", c0, 2048);
      count_led(0, 2048, c0);
      check("reenable_led0_off_phase", c0, 0);
      // unmapped index: reads 0, leaves the register file intact
      wr(16'h7F, 16'hFFFF);
      rd(16'h7F, 16'h0);
      rd(0, 16'h1);
      rd(1, 16'h3);
      rd(2, 16'h1);
      rd(3, 16'h1);
      rd(4, 16'h00FF);
      rd(5, 16'h00FF);
      rd(7, 16'h0080);
      // reset during access phase
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h1; pwdata = 16'h0055;
      @(negedge clk);
      penable = 1'b1; preset = 1'b1;
      @(negedge clk);
      check("reset_mid_xfer_pready", int'(o_pready), 0);
      psel = 1'b0; penable = 1'b0; preset = 1'b0;
      rd(1, 16'h0);
      rd(0, 16'h0);
      check("reset_mid_xfer_leds", int'(o_leds), 0);
      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/apb_led_pwm.md
# apb_led_pwm

Parametrised APB LED peripheral: NUM_LEDS outputs, each with its own PWM brightness duty, plus a shared blink generator gated per channel by a mask. It sits on the APB peripheral bus beside the DMA/RISC-V subsystem and replaces the fixed two-register on/off LED block. It adds a prescaled PWM timebase, glitch-free duty updates via shadow registers, and a one-wait-state APB handshake.

## Interface
- NUM_LEDS, 16: LED channel count, 1..APB_DATA_WIDTH
- PWM_WIDTH, 8: duty/PWM counter width
- APB_ADDR_WIDTH, 16: APB address width
- APB_DATA_WIDTH, 16: APB data width, ≥ PWM_WIDTH and ≥ NUM_LEDS
- pclk  in  1  sole clock, all state on rising edge
- preset  in  1  reset, synchronous and active-high
- i_psel  in  1  APB select
- i_penable  in  1  APB access phase
- i_pwrite  in  1  1 = write
- i_paddr  in  APB_ADDR_WIDTH  word index of register
- i_pwdata  in  APB_DATA_WIDTH  write data
- o_pready  out  1  transfer complete
- o_prdata  out  APB_DATA_WIDTH  read data, valid while o_pready=1
- o_leds  out  NUM_LEDS  registered LED drive, bit i = channel i

## Operation
- Register map (word index): 0 CTRL (bit0 EN, other bits read 0); 1 PRESCALE; 2 BLINK_PERIOD; 3 BLINK_MASK (low NUM_LEDS bits); 4..4+NUM_LEDS-1 DUTY[i] (low PWM_WIDTH bits). Unmapped index: reads 0, writes ignored. Unused upper data bits read 0.
- Reset values: all registers 0, shadow duties 0, all counters 0, blink phase 1 (on), o_leds 0, o_pready 0, o_prdata 0.
- Prescaler: counts 0..PRESCALE while EN=1; tick asserted on the cycle it equals PRESCALE, then reloads 0. PRESCALE=0 ⇒ tick every cycle.
- PWM counter: PWM_WIDTH bits, increments on tick, wraps 2^PWM_WIDTH-1 → 0; wrap event = tick while counter is max.
- Shadow duty: DUTY[i] copied into shadow[i] on wrap event, or every cycle while EN=0. Duty writes never change a period mid-flight.
- Blink: blink counter increments on wrap event; on wrap event with counter == BLINK_PERIOD it clears and blink phase toggles. BLINK_PERIOD=0 ⇒ toggle every PWM period.
- LED compare: on_i = EN & ((shadow[i] == all-ones) | (pwm_cnt < shadow[i])) & (~BLINK_MASK[i] | phase). Duty 0 ⇒ always off, all-ones ⇒ always on.
- EN=0: prescaler, PWM and blink counters held at 0, phase forced 1; o_leds goes 0.

## Timing
- APB: o_pready_next = i_psel & i_penable & ~o_pready; exactly one wait state, o_pready high one cycle, then low.
- Completion cycle = i_psel & i_penable & o_pready. Write commits at that edge. o_prdata registered at the same edge that sets o_pready, so it is valid in the completion cycle.
- Back-to-back transfers: o_pready low for at least the setup cycle between them. Deasserting i_psel mid-access drops the transfer with no write.
- o_leds: one-cycle latency from counter/shadow state, registered, glitch-free.
- New duty visible from the first PWM period after the next wrap event. CTRL EN write acts in the cycle after completion.
- Simultaneous wrap event and DUTY[i] write: shadow[i] takes the old DUTY. The new value applies one period later.
- preset mid-transfer: o_pready 0 next cycle, write lost; the master must restart.

## Structure
- Shared package apb_led_pwm_pkg: register index localparams (REG_CTRL=0, REG_PRESCALE=1, REG_BLINK=2, REG_MASK=3, REG_DUTY0=4) and the CTRL bit position.
- Sub-module led_pwm_channel, instantiated NUM_LEDS times. It holds the shadow duty, compare and output flop, with inputs duty, load, pwm_cnt, gate.
- The top level holds the APB slave, register file, prescaler, PWM counter and blink generator.

## Test plan
- Reset, then read all indices 0..4+NUM_LEDS → all 0. Each read completes with o_pready high exactly one cycle after the access phase starts.
- Write DUTY0=0x40, PRESCALE=0, EN=1 → after the first wrap, o_leds[0] high 64 of every 256 cycles and other LEDs 0. Write DUTY0=0xFF → constantly high from the next period.
- Write DUTY3=0x80 on the cycle of a wrap event → the current period uses the old duty and the next period shows 128 high cycles.
- PRESCALE=3, BLINK_PERIOD=1, MASK=0x0001, DUTY0=DUTY1=0xFF → LED1 constantly on. LED0 alternates on/off every 2 PWM periods (2048 cycles).
- Clear EN mid-period → o_leds 0 next cycle and counters read-back state restarts from 0 on re-enable. Assert preset during an access phase → o_pready stays 0 and the register is unchanged.
- Write to index 0x7F and read it → returns 0, no register changes, handshake still completes.
